// File: rtl/time_display_ctrl.sv
// Countdown/overdue timer with a sign+BCD count, a frame-synchronised shadow copy,
// and a three-slot (minus, tens, ones) pixel decoder for a shared glyph renderer.
module time_display_ctrl #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned X0       = 600,
    parameter int unsigned Y0       = 20,
    parameter int unsigned WIDTH    = 18,
    parameter int unsigned HEIGHT   = 25,
    parameter int unsigned GAP      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [6:0]  i_load_val,
    input  logic        i_pause,
    input  logic        i_clear,
    input  logic        i_frame_start,
    input  logic [12:0] i_H_Cont,
    input  logic [12:0] i_V_Cont,
    output logic        o_en,
    output logic        o_minus,
    output logic [3:0]  o_time,
    output logic [12:0] o_x,
    output logic [12:0] o_y,
    output logic        o_expired,
    output logic [1:0]  o_state
);

    localparam int unsigned PW    = $clog2(TICK_DIV);
    localparam int unsigned PITCH = WIDTH + GAP;

    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    localparam logic [12:0] X0_C  = 13'(X0);
    localparam logic [12:0] Y0_C  = 13'(Y0);
    localparam logic [12:0] S1_X  = 13'(X0 + PITCH);
    localparam logic [12:0] S2_X  = 13'(X0 + 2 * PITCH);
    localparam logic [12:0] S0_E  = 13'(X0 + WIDTH);
    localparam logic [12:0] S1_E  = 13'(X0 + PITCH + WIDTH);
    localparam logic [12:0] S2_E  = 13'(X0 + 2 * PITCH + WIDTH);
    localparam logic [12:0] Y_END = 13'(Y0 + HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_OVER  = 2'b10,
        ST_SAT   = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic          sign_q, sign_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          expired_q, expired_d;

    logic          sh_sign_q;
    logic [3:0]    sh_tens_q;
    logic [3:0]    sh_ones_q;
    logic          sh_act_q;

    logic          running;
    logic          tick;
    logic [7:0]    load_bcd;
    logic          in_rows;

    // Clamp to 99 and split into BCD with a compare chain instead of a divider.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] r;
        logic [3:0] t;
        r = (v > 7'd99) ? 7'd99 : v;
        t = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            if (r >= 7'(10 * k)) t = 4'(k);
        end
        r = r - 7'(10 * t);
        return {t, 4'(r)};
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            sign_q    <= 1'b0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            pre_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            pre_q     <= pre_d;
            expired_q <= expired_d;
        end
    end

    // Next state: clear beats start beats tick.
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        pre_d     = pre_q;
        expired_d = 1'b0;
        running   = ((state_q == ST_COUNT) || (state_q == ST_OVER)) && !i_pause;
        tick      = running && (pre_q == PRE_MAX);
        load_bcd  = to_bcd(i_load_val);

        if (i_clear) begin
            state_d = ST_IDLE;
            sign_d  = 1'b0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            pre_d   = '0;
        end else if (i_start) begin
            state_d = ST_COUNT;
            sign_d  = 1'b0;
            tens_d  = load_bcd[7:4];
            ones_d  = load_bcd[3:0];
            pre_d   = '0;
        end else if (running) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                if (state_q == ST_COUNT) begin
                    if ((tens_q == 4'd0) && (ones_q == 4'd0)) begin
                        ones_d  = 4'd1;
                        sign_d  = 1'b1;
                        state_d = ST_OVER;
                    end else begin
                        if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                        expired_d = (tens_q == 4'd0) && (ones_q == 4'd1);
                    end
                end else begin
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                    if ((tens_q == 4'd9) && (ones_q == 4'd8)) state_d = ST_SAT;
                end
            end
        end
    end

    // Shadow copy taken only at frame start so a frame never shows a torn count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_sign_q <= 1'b0;
            sh_tens_q <= 4'd0;
            sh_ones_q <= 4'd0;
            sh_act_q  <= 1'b0;
        end else if (i_frame_start) begin
            sh_sign_q <= sign_q;
            sh_tens_q <= tens_q;
            sh_ones_q <= ones_q;
            sh_act_q  <= (state_q != ST_IDLE);
        end
    end

    assign o_state   = state_q;
    assign o_expired = expired_q;

    // Slot decode is combinational so the renderer sees no extra latency.
    always_comb begin
        o_en    = 1'b0;
        o_minus = 1'b0;
        o_time  = 4'd0;
        o_x     = X0_C;
        o_y     = Y0_C;
        in_rows = (i_V_Cont >= Y0_C) && (i_V_Cont < Y_END);

        if (in_rows && (i_H_Cont >= X0_C) && (i_H_Cont < S0_E)) begin
            o_minus = 1'b1;
            o_en    = sh_sign_q && sh_act_q;
        end else if (in_rows && (i_H_Cont >= S1_X) && (i_H_Cont < S1_E)) begin
            o_time = sh_tens_q;
            o_en   = sh_act_q;
            o_x    = S1_X;
        end else if (in_rows && (i_H_Cont >= S2_X) && (i_H_Cont < S2_E)) begin
            o_time = sh_ones_q;
            o_en   = sh_act_q;
            o_x    = S2_X;
        end
    end

endmodule
